// File: rtl/seven_seg_scanner_if.sv
// Load-side handshake for the seven-segment scanner: a 16-bit hex value plus
// per-digit decimal points, transferred on load_valid && load_ready.
interface seven_seg_scanner_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_dp;

  modport master (
    output load_valid,
    output load_value,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    input  load_dp,
    output load_ready
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner. Each digit slot is an optional
// all-dark blanking phase followed by a lit phase; four slots form a frame.
// New values land in a pending buffer and are promoted to the displayed value
// only on the last cycle of a frame, so a frame never mixes two values.
module seven_seg_scanner #(
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                      clk,
  input  logic                      rst,
  seven_seg_scanner_if.slave        load_if,
  input  logic                      lz_en,
  output logic                      x3,
  output logic                      x2,
  output logic                      x1,
  output logic                      x0,
  output logic                      dp_n,
  output logic [3:0]                an_n,
  output logic                      frame_tick
);

  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam int CNT_MAX   = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  localparam state_t RST_STATE = HAS_BLANK ? ST_BLANK : ST_ON;

  // Scan state
  state_t           r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;

  // Displayed and pending values
  logic [15:0] r_act_val;
  logic [3:0]  r_act_dp;
  logic [15:0] r_pend_val;
  logic [3:0]  r_pend_dp;
  logic        r_load_ready;

  // Registered display outputs
  logic [3:0] r_an_n;
  logic [3:0] r_x;
  logic       r_dp_n;
  logic       r_frame_tick;

  // Next-state and output-decode nets
  state_t           w_state_nx;
  logic [1:0]       w_idx_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_boundary;
  logic             w_apply;
  logic             w_take;
  logic [15:0]      w_act_val_nx;
  logic [3:0]       w_act_dp_nx;
  logic [3:0]       w_nib;
  logic             w_upper_zero;
  logic             w_sup;
  logic             w_lit;
  logic             w_tick_nx;

  // Slot sequencing: count out each phase, then step to the next phase/digit.
  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt + CNT_W'(1);
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          w_state_nx = ST_ON;
          w_cnt_nx   = '0;
        end
      end
      ST_ON: begin
        if (r_cnt == CNT_W'(ON_CYCLES - 1)) begin
          w_cnt_nx   = '0;
          w_idx_nx   = r_idx + 2'd1;
          w_state_nx = HAS_BLANK ? ST_BLANK : ST_ON;
        end
      end
      default: begin
        w_state_nx = RST_STATE;
      end
    endcase
  end

  // Frame boundary is the final lit cycle of digit 3.
  assign w_boundary = (r_state == ST_ON) && (r_idx == 2'd3) &&
                      (r_cnt == CNT_W'(ON_CYCLES - 1));
  assign w_apply    = w_boundary && !r_load_ready;
  assign w_take     = load_if.load_valid && r_load_ready;

  // Outputs are decoded from the value that will be active next cycle, so a
  // promotion at the boundary shows up on the very first cycle of digit 0.
  assign w_act_val_nx = w_apply ? r_pend_val : r_act_val;
  assign w_act_dp_nx  = w_apply ? r_pend_dp  : r_act_dp;

  // Select the nibble for the upcoming digit and decide leading-zero blanking.
  always_comb begin
    w_nib        = w_act_val_nx[3:0];
    w_upper_zero = 1'b0;
    case (w_idx_nx)
      2'd0: begin
        w_nib        = w_act_val_nx[3:0];
        w_upper_zero = 1'b0;
      end
      2'd1: begin
        w_nib        = w_act_val_nx[7:4];
        w_upper_zero = (w_act_val_nx[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib        = w_act_val_nx[11:8];
        w_upper_zero = (w_act_val_nx[15:8] == 8'h00);
      end
      default: begin
        w_nib        = w_act_val_nx[15:12];
        w_upper_zero = (w_act_val_nx[15:12] == 4'h0);
      end
    endcase
  end

  assign w_sup     = lz_en && w_upper_zero && !w_act_dp_nx[w_idx_nx];
  assign w_lit     = (w_state_nx == ST_ON) && !w_sup;
  assign w_tick_nx = (w_state_nx == ST_ON) && (w_idx_nx == 2'd3) &&
                     (w_cnt_nx == CNT_W'(ON_CYCLES - 1));

  // Scan FSM with registered display outputs for the state being entered.
  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RST_STATE;
      r_idx        <= 2'd0;
      r_cnt        <= '0;
      r_an_n       <= 4'b1111;
      r_x          <= 4'h0;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_cnt        <= w_cnt_nx;
      r_an_n       <= w_lit ? ~(4'b0001 << w_idx_nx) : 4'b1111;
      r_x          <= w_nib;
      r_dp_n       <= w_lit ? ~w_act_dp_nx[w_idx_nx] : 1'b1;
      r_frame_tick <= w_tick_nx;
    end
  end

  // Double buffer: accept into pending when empty, promote at the frame boundary.
  // NOTE: the data registers are reset too, because a mid-frame reset must show 0 rather than stale digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_val    <= 16'h0000;
      r_act_dp     <= 4'b0000;
      r_pend_val   <= 16'h0000;
      r_pend_dp    <= 4'b0000;
      r_load_ready <= 1'b1;
    end else begin
      r_act_val <= w_act_val_nx;
      r_act_dp  <= w_act_dp_nx;
      if (w_apply) begin
        r_load_ready <= 1'b1;
      end else if (w_take) begin
        r_pend_val   <= load_if.load_value;
        r_pend_dp    <= load_if.load_dp;
        r_load_ready <= 1'b0;
      end
    end
  end

  assign load_if.load_ready = r_load_ready;
  assign {x3, x2, x1, x0}   = r_x;
  assign dp_n               = r_dp_n;
  assign an_n               = r_an_n;
  assign frame_tick         = r_frame_tick;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two instances (blanking on / blanking off) see
// the same stimulus; a frame-position model predicts every output each cycle.
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic lz_en;

  seven_seg_scanner_if if0 ();
  seven_seg_scanner_if if1 ();

  logic [3:0] an0, an1, xs0, xs1;
  logic       dpn0, dpn1, tk0, tk1;

  seven_seg_scanner #(.ON_CYCLES(3), .BLANK_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .load_if(if0), .lz_en(lz_en),
    .x3(xs0[3]), .x2(xs0[2]), .x1(xs0[1]), .x0(xs0[0]),
    .dp_n(dpn0), .an_n(an0), .frame_tick(tk0)
  );

  seven_seg_scanner #(.ON_CYCLES(2), .BLANK_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .load_if(if1), .lz_en(lz_en),
    .x3(xs1[3]), .x2(xs1[2]), .x1(xs1[1]), .x0(xs1[0]),
    .dp_n(dpn1), .an_n(an1), .frame_tick(tk1)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Stimulus shared by both instances
  logic        s_valid = 1'b0;
  logic [15:0] s_val   = 16'h0000;
  logic [3:0]  s_dp    = 4'b0000;
  logic        s_lz    = 1'b0;

  // Reference model: cycle number since reset plus the two value buffers
  int          k;
  logic        m_lz;
  logic [15:0] m_act [2];
  logic [3:0]  m_adp [2];
  logic [15:0] m_pv  [2];
  logic [3:0]  m_pdp [2];
  bit          m_full[2];
  bit          m_took[2];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic int blank_of(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int on_of(int d);
    return (d == 0) ? 3 : 2;
  endfunction

  task automatic drive();
    if0.load_valid = s_valid; if0.load_value = s_val; if0.load_dp = s_dp;
    if1.load_valid = s_valid; if1.load_value = s_val; if1.load_dp = s_dp;
    lz_en = s_lz;
  endtask

  // Compare both instances against the expected picture for cycle k.
  task automatic check_cycle();
    int sl, p, dig, off;
    logic [3:0] e_an, e_x;
    logic e_dp, e_tick, e_lit, sup;
    for (int d = 0; d < 2; d++) begin
      e_an = 4'hf; e_x = 4'h0; e_dp = 1'b1; e_tick = 1'b0; e_lit = 1'b0;
      if (k > 0) begin
        sl     = blank_of(d) + on_of(d);
        p      = k % (4 * sl);
        dig    = p / sl;
        off    = p % sl;
        e_tick = (p == 4 * sl - 1);
        if (off >= blank_of(d)) begin
          sup = m_lz && (dig > 0) && !m_adp[d][dig] && ((m_act[d] >> (4 * dig)) == 16'h0);
          if (!sup) begin
            e_lit = 1'b1;
            e_an  = ~(4'b0001 << dig);
            e_x   = 4'((m_act[d] >> (4 * dig)) & 16'h000f);
            e_dp  = ~m_adp[d][dig];
          end
        end
      end
      check($sformatf("d%0d_an", d),    (d == 0) ? an0 : an1, e_an);
      check($sformatf("d%0d_dp_n", d),  (d == 0) ? dpn0 : dpn1, e_dp);
      check($sformatf("d%0d_tick", d),  (d == 0) ? tk0 : tk1, e_tick);
      check($sformatf("d%0d_ready", d), (d == 0) ? if0.load_ready : if1.load_ready, !m_full[d]);
      if (e_lit) check($sformatf("d%0d_x", d), (d == 0) ? xs0 : xs1, e_x);
    end
  endtask

  // Apply stimulus, advance the model across one rising edge, then check.
  task automatic step();
    int sl;
    bit bnd;
    drive();
    for (int d = 0; d < 2; d++) begin
      sl        = blank_of(d) + on_of(d);
      bnd       = (k > 0) && ((k % (4 * sl)) == 4 * sl - 1);
      m_took[d] = 1'b0;
      if (bnd && m_full[d]) begin
        m_act[d]  = m_pv[d];
        m_adp[d]  = m_pdp[d];
        m_full[d] = 1'b0;
      end else if (s_valid && !m_full[d]) begin
        m_pv[d]   = s_val;
        m_pdp[d]  = s_dp;
        m_full[d] = 1'b1;
        m_took[d] = 1'b1;
      end
    end
    @(negedge clk);
    k++;
    m_lz = s_lz;
    check_cycle();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    k = 0;
    m_lz = s_lz;
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 16'h0; m_adp[d] = 4'h0; m_pv[d] = 16'h0; m_pdp[d] = 4'h0;
      m_full[d] = 1'b0; m_took[d] = 1'b0;
    end
  endtask

  // Offer a value until both instances have taken it (bounded).
  task automatic offer(logic [15:0] v, logic [3:0] dp);
    bit got0, got1;
    int n;
    got0 = 1'b0; got1 = 1'b0; n = 0;
    s_valid = 1'b1; s_val = v; s_dp = dp;
    while (!(got0 && got1) && n < 100) begin
      step();
      got0 |= m_took[0];
      got1 |= m_took[1];
      n++;
    end
    s_valid = 1'b0;
    check("offer_accept", {30'd0, got0, got1}, 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    logic [31:0] r;
    rst = 1'b1;
    drive();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_cycle();

    // Scan order with 1234
    offer(16'h1234, 4'b0000);
    run(40);

    // Double buffer: ABCD then a held 5555 offer
    offer(16'hABCD, 4'b0000);
    s_valid = 1'b1; s_val = 16'h5555; s_dp = 4'b0000;
    run(60);
    s_valid = 1'b0;
    run(20);

    // Leading-zero suppression
    s_lz = 1'b1;
    offer(16'h0070, 4'b0000);
    run(40);
    s_lz = 1'b0;
    run(20);
    s_lz = 1'b1;
    offer(16'h0000, 4'b0000);
    run(40);

    // Decimal point keeps a zero digit lit
    offer(16'h0012, 4'b0100);
    run(40);

    // Randomized loads, decimal points and lz toggles
    for (int i = 0; i < 600; i++) begin
      s_valid = ($urandom_range(0, 7) == 0);
      r = $urandom;
      case ($urandom_range(0, 3))
        0: s_val = {12'h000, r[3:0]};
        1: s_val = {8'h00, r[7:0]};
        2: s_val = {4'h0, r[11:0]};
        default: s_val = r[15:0];
      endcase
      s_dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 31) == 0) s_lz = ~s_lz;
      step();
    end

    // Async reset during digit 2 of the blanking instance, pending full
    s_lz = 1'b0;
    s_valid = 1'b1; s_val = 16'h9876; s_dp = 4'b0000;
    found = 1'b0; n = 0;
    while (!found && n < 200) begin
      step();
      found = m_full[0] && ((k % 16) >= 9) && ((k % 16) <= 11);
      n++;
    end
    check("mid_reach", {31'd0, found}, 32'd1);
    s_valid = 1'b0;
    drive();
    #2 rst = 1'b1;
    #1;
    check("async_an0", an0, 4'hf);
    check("async_an1", an1, 4'hf);
    check("async_rdy0", if0.load_ready, 1'b1);
    check("async_rdy1", if1.load_ready, 1'b1);
    check("async_x0", xs0, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_cycle();
    run(40);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Upstream stage of the hex seven-segment decoder: time-multiplexes a 16-bit value across four common-anode digits.
- Each scan slot presents one nibble on x3..x0, which the decoder turns into active-low segments A..G.
- Drives the active-low anode enables, the decimal point, optional leading-zero suppression and inter-digit blanking against ghosting.
- Accepts new values by valid/ready handshake. A double buffer applies them only at frame boundaries, so the display never tears.

Parameters:
ON_CYCLES, 50000, clock cycles each digit is lit per slot (>=1)
BLANK_CYCLES, 2000, clock cycles all anodes are off before each digit (>=0; 0 disables blanking)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
load_valid  input  1  new display value offered
load_ready  output  1  pending buffer empty; transfer when load_valid&load_ready at clk edge
load_value  input  16  hex value; [3:0]=digit 0 (rightmost) ... [15:12]=digit 3
load_dp  input  4  decimal point per digit, 1=lit; bit i = digit i
lz_en  input  1  leading-zero suppression enable (level, sampled continuously)
x3  output  1  nibble bit 3 to decoder
x2  output  1  nibble bit 2
x1  output  1  nibble bit 1
x0  output  1  nibble bit 0
dp_n  output  1  decimal point, active-low
an_n  output  4  anode enables, active-low; bit i = digit i
frame_tick  output  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock, asynchronous active-high reset. All state is cleared immediately on rst assertion, independent of clk.
- Reset values:
  - active value = 0, active dp = 0
  - pending buffer empty, so load_ready = 1
  - digit index = 0; slot counter = 0
  - state = BLANK if BLANK_CYCLES>0, else ON
  - an_n = 4'b1111, {x3,x2,x1,x0} = 0, dp_n = 1, frame_tick = 0
- All outputs are registered.
- State machine, per digit slot:
  - BLANK: an_n=1111, dp_n=1; lasts BLANK_CYCLES cycles, then ON.
  - ON: lasts ON_CYCLES cycles. an_n has only bit idx low, unless the digit is suppressed (then 1111). {x3..x0} = active nibble idx. dp_n = ~active_dp[idx].
  - At the end of ON, idx advances 0->1->2->3->0 (wraps). Next state is BLANK, or ON when BLANK_CYCLES=0.
- Slot length = BLANK_CYCLES+ON_CYCLES. Frame = 4 slots.
- Output timing: outputs for a state are valid from the first cycle of that state. The registers update on the edge that enters the state.
- Frame boundary = the last cycle of digit 3's ON state. On that cycle:
  - frame_tick=1.
  - If the pending buffer was full at the start of the cycle: active <= pending, pending cleared, load_ready returns to 1 on the next cycle.
  - The new value is therefore shown from digit 0 of the next frame.
- Handshake:
  - A transfer occurs when load_valid&&load_ready on a clk edge. The pending buffer is written and load_ready drops the next cycle.
  - load_valid while load_ready=0 is ignored; nothing is overwritten or queued.
  - A transfer on the frame-boundary cycle while pending was empty is stored. It is applied at the following boundary, not the current one.
- Leading-zero suppression:
  - Digit i (i=1..3) is suppressed when lz_en=1, active_dp[i]=0, and active nibbles i..3 are all zero.
  - Digit 0 is never suppressed.
  - While suppressed, an_n stays 1111 and dp_n=1 for the slot. Timing is unchanged.
- Reset mid-frame: scan restarts at digit 0 and any pending value is discarded.

Test Plan:
- Reset/scan order (ON_CYCLES=3, BLANK_CYCLES=1):
  - Stimulus: hold rst, release; load 16'h1234, dp=0000.
  - After reset: an_n=1111.
  - After the first boundary: each 4-cycle slot gives 1 blank cycle (an_n=1111), then 3 cycles of an_n=1110/x=4, 1101/x=3, 1011/x=2, 0111/x=1.
  - frame_tick fires every 16 cycles.
- Handshake/double buffer:
  - Stimulus: load 16'hABCD, then hold load_valid with 16'h5555.
  - load_ready=0 until the boundary. Digits keep showing the current frame with no mixed nibbles.
  - ABCD appears from digit 0 of the next frame. The second value is accepted only after load_ready returns to 1.
- Leading zeros:
  - Stimulus: value 16'h0070, lz_en=1.
  - Digit 3 and digit 2 slots have an_n=1111. Digit 1 shows 7, digit 0 shows 0.
  - With lz_en=0, all four digits light.
  - With value 16'h0000, only digit 0 lights.
- Decimal point: dp=0100, value 16'h0012, lz_en=1 -> digit 2 is lit showing 0 with dp_n=0. Digit 3 is suppressed. dp_n=1 in all other slots.
- No blanking: BLANK_CYCLES=0, ON_CYCLES=2 -> an_n never 1111 outside suppression; frame_tick every 8 cycles.
- Async reset mid-frame: assert rst between clk edges during digit 2 with a pending value -> an_n=1111 and load_ready=1 immediately. After release, scan restarts at digit 0 showing 0.
